// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_result_stage_pkg : shared ALU widths, opcodes, stage states
// Revision: 1.0
// ------------------------------------------------------------------
package alu_result_stage_pkg;

  localparam int ALU_WIDTH   = 8;
  localparam int ALU_NUM_OPS = 8;
  localparam int ALU_OP_W    = $clog2(ALU_NUM_OPS);

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_NOT  = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_NAND = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHL  = 3'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  op;
    logic [ALU_WIDTH-1:0] result;
    logic                 z;
    logic                 n;
    logic                 p;
  } alu_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_result_stage_if : operation bus in, flagged result out
// Revision: 1.0
// ------------------------------------------------------------------
interface alu_result_stage_if
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int NUM_OPS = ALU_NUM_OPS
);
  localparam int OP_W = $clog2(NUM_OPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [OP_W-1:0]          op_sel;
  logic [NUM_OPS*WIDTH-1:0] op_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         result;
  logic                     flag_z;
  logic                     flag_n;
  logic                     flag_p;
  logic [OP_W-1:0]          op_out;

  modport master (
    output in_valid, op_sel, op_bus, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_p, op_out
  );

  modport slave (
    input  in_valid, op_sel, op_bus, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_p, op_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage_flag_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_flag_gen : zero / negative / parity status of one value
// Revision: 1.0
// ------------------------------------------------------------------
module alu_flag_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             z,
  output logic             n,
  output logic             p
);
  assign z = ~|value;
  assign n = value[WIDTH-1];
  assign p = ^value;
endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_result_stage : opcode slice select, flag capture, 2-entry skid
// Revision: 1.0
// ------------------------------------------------------------------
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int NUM_OPS = ALU_NUM_OPS
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus
);
  localparam int OP_W = $clog2(NUM_OPS);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             p;
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sel_slice;
  logic             sel_z, sel_n, sel_p;
  entry_t           new_entry;
  logic             in_fire, out_fire;

  // Unmatched selects (only possible with non-power-of-two NUM_OPS) give zero.
  always_comb begin
    sel_slice = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (bus.op_sel == OP_W'(i)) sel_slice = bus.op_bus[i*WIDTH +: WIDTH];
    end
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .value (sel_slice),
    .z     (sel_z),
    .n     (sel_n),
    .p     (sel_p)
  );

  assign new_entry = '{op: bus.op_sel, result: sel_slice, z: sel_z, n: sel_n, p: sel_p};
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = (state_q != ST_EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = new_entry;
        end else if (in_fire) begin
          skid_d  = new_entry;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready looks ahead at the next state, keeping out_ready off the input path.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.result    = main_q.result;
  assign bus.flag_z    = main_q.z;
  assign bus.flag_n    = main_q.n;
  assign bus.flag_p    = main_q.p;
  assign bus.op_out    = main_q.op;
endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_result_stage : directed + random bench with queue model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(8), .NUM_OPS(8)) bus ();

  alu_result_stage #(.WIDTH(8), .NUM_OPS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int op;
    int val;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model flags straight from the value's arithmetic meaning.
  function automatic int exp_z(input int v); return (v == 0) ? 1 : 0; endfunction
  function automatic int exp_n(input int v); return (v >= 128) ? 1 : 0; endfunction
  function automatic int exp_p(input int v); return $countones(v[7:0]) % 2; endfunction

  task automatic set_beat(input int op, input int val, input bit fill_a5);
    logic [63:0] b;
    for (int i = 0; i < 8; i++) b[i*8 +: 8] = fill_a5 ? 8'hA5 : 8'($urandom);
    b[op*8 +: 8] = 8'(val);
    bus.op_bus = b;
    bus.op_sel = 3'(op);
  endtask

  // One clock: check outputs against the model, predict transfers, advance.
  task automatic step(output bit in_fire);
    bit out_fire;
    int v;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    chk("in_ready", int'(bus.in_ready), (q.size() < 2) ? 1 : 0);
    chk("out_valid", int'(bus.out_valid), (q.size() != 0) ? 1 : 0);
    if (q.size() != 0) begin
      v = q[0].val;
      chk("result", int'(bus.result), v);
      chk("op_out", int'(bus.op_out), q[0].op);
      chk("flag_z", int'(bus.flag_z), exp_z(v));
      chk("flag_n", int'(bus.flag_n), exp_n(v));
      chk("flag_p", int'(bus.flag_p), exp_p(v));
    end
    if (!rst_n) begin
      q.delete();
      in_fire = 1'b0;
    end else begin
      if (out_fire && q.size() != 0) void'(q.pop_front());
      if (in_fire) q.push_back('{op: int'(bus.op_sel), val: int'(bus.op_bus[bus.op_sel*8 +: 8])});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit f;
    int idx, sent, val;
    int bp_data[3];
    bp_data[0] = 8'h01; bp_data[1] = 8'h02; bp_data[2] = 8'h03;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_beat(6, 0, 1'b0);

    // Reset values
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_flags", int'({bus.flag_z, bus.flag_n, bus.flag_p}), 0);
    chk("rst_op_out", int'(bus.op_out), 0);
    rst_n = 1'b1;

    // Single NAND beat of 0xFF
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_beat(6, 8'hFF, 1'b0);
    step(f);
    bus.in_valid = 1'b0;
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_result", int'(bus.result), 8'hFF);
    chk("single_flags_znp", int'({bus.flag_z, bus.flag_n, bus.flag_p}), 3'b010);
    chk("single_op", int'(bus.op_out), 6);
    step(f);
    chk("single_empty", int'(bus.out_valid), 0);

    // Zero result, neighbours all 0xA5
    bus.in_valid = 1'b1;
    set_beat(6, 8'h00, 1'b1);
    step(f);
    bus.in_valid = 1'b0;
    chk("zero_result", int'(bus.result), 0);
    chk("zero_flags_znp", int'({bus.flag_z, bus.flag_n, bus.flag_p}), 3'b100);
    step(f);

    // Backpressure fill: three beats offered, two fit
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_valid = 1'b1;
    set_beat(6, bp_data[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(f);
      if (f) begin
        idx++;
        if (idx < 3) set_beat(6, bp_data[idx], 1'b0);
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_held_result", int'(bus.result), 8'h01);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 3 && q.size() == 0); c++) begin
      step(f);
      if (f) begin
        idx++;
        if (idx >= 3) bus.in_valid = 1'b0;
        else set_beat(6, bp_data[idx], 1'b0);
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_drained", (idx == 3 && q.size() == 0) ? 1 : 0, 1);

    // Streaming: one beat per cycle, output lags by one
    bus.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      set_beat(c % 8, 8'h40 + c, 1'b0);
      step(f);
      chk("stream_in_ready", int'(bus.in_ready), 1);
      chk("stream_delay1", int'(bus.result), 8'h40 + c);
    end
    bus.in_valid = 1'b0;
    step(f);

    // Reset while FULL with 0x11 / 0x22
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_beat(4, 8'h11, 1'b0);
    step(f);
    set_beat(4, 8'h22, 1'b0);
    step(f);
    bus.in_valid = 1'b0;
    chk("mid_full", int'(bus.in_ready), 0);
    rst_n = 1'b0;
    step(f);
    rst_n = 1'b1;
    chk("mid_out_valid", int'(bus.out_valid), 0);
    chk("mid_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(f);
      chk("mid_no_ghost", int'(bus.out_valid), 0);
    end

    // Random valid/ready stress; a pending beat holds until accepted
    sent = 0;
    f = 1'b1;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      if (!bus.in_valid || f) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        val = int'($urandom_range(0, 255));
        set_beat(int'($urandom_range(0, 7)), val, 1'b0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(f);
      if (f) sent++;
    end
    chk("stress_beats", sent, 10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step(f);
    chk("stress_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 8-bit ALU operation units (bitwise NAND and its sibling operation blocks). Each unit drives its own 8-bit output.
- Selects one operation output by opcode, computes status flags and registers the result toward the accumulator/writeback.
- Uses a 2-entry skid buffer with valid/ready on both sides. Full throughput, no combinational ready path from output to input.

Parameters:
- WIDTH, 8, datapath width of each operation output and of result.
- NUM_OPS, 8, number of operation outputs on the input bus; opcode width is log2(NUM_OPS) = 3.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  upstream has a valid op_sel/op_bus pair.
- in_ready  output  1  stage can accept; registered, not derived from out_ready.
- op_sel  input  3  opcode; selects slice op_bus[op_sel*WIDTH +: WIDTH]; opcode 6 = NAND output.
- op_bus  input  NUM_OPS*WIDTH  concatenated operation outputs; slice i = operation i.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts.
- result  output  WIDTH  selected operation output.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_p  output  1  even parity: XOR-reduce of result.
- op_out  output  3  opcode that produced result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Reset values (rst_n low at an edge): out_valid=0, in_ready=1, result=0, flag_z=0, flag_n=0, flag_p=0, op_out=0, both buffer entries invalid.
- Reset mid-operation discards both entries. Any beat held but not yet accepted is lost; no partial output.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Flags are computed on the selected slice at capture time and stored with it. They never change while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge k is presented at out_valid after edge k (1 cycle) when the stage is empty.
- Storage: main entry (drives outputs) and skid entry. State encoding: EMPTY (no entries), ONE (main valid), FULL (main + skid valid).
- Transitions:
  - EMPTY: input transfer -> load main, go ONE.
  - ONE, input only -> load skid, go FULL.
  - ONE, output only -> go EMPTY.
  - ONE, input and output in the same edge -> reload main with new beat, stay ONE.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so no input transfer. Output transfer -> skid moves to main, go ONE. Otherwise hold.
- Outputs by state:
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
- Ordering is strict FIFO: no beat is dropped or duplicated.
- Input signals are ignored when in_ready=0 or in_valid=0.
- op_sel values >= NUM_OPS are not possible at the default; with a non-power-of-two NUM_OPS, out-of-range selects yield result=0.
- Width rules: no arithmetic; slices are passed through unmodified.

Decomposition:
- Shared ALU package:
  - WIDTH and NUM_OPS defaults.
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_NAND=6, OP_SHL=7.
  - State-encoding constants EMPTY/ONE/FULL.
  - Packed record type {op, result, z, n, p} for buffer entries.
- One sub-module is natural: alu_flag_gen. It is combinational, takes a WIDTH-bit value and produces z, n, p. It is instantiated once on the selected slice before capture.

Test Plan:
- Reset then single beat: rst_n low 2 cycles; op_sel=6, NAND slice=8'hFF, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, result=8'hFF, flag_z=0, flag_n=1, flag_p=0, op_out=6; then EMPTY.
- Zero result: op_sel=6 with slice 8'h00, other slices 8'hA5 -> result=8'h00, flag_z=1, flag_n=0, flag_p=0; confirms slice selection.
- Backpressure fill: out_ready=0, send 3 beats (8'h01, 8'h02, 8'h03) -> first two accepted, in_ready=0 after the second, third held upstream; result stays 8'h01 with stable flags. Release out_ready -> results 8'h01, 8'h02, 8'h03 in order.
- Streaming: in_valid=out_ready=1 for 16 cycles with incrementing data -> one result per cycle, in_ready never drops, output equals input delayed 1 cycle.
- Reset mid-operation: FULL state with 8'h11 and 8'h22 held, assert rst_n low 1 cycle -> out_valid=0, in_ready=1 next cycle; neither 8'h11 nor 8'h22 ever appears.
- Random valid/ready stress, 10k beats: scoreboard order and flag correctness; check outputs are stable while out_valid & !out_ready.
